// File: rtl/ctrl_pkg.sv
// Shared types and opcode tables for the LEGv8 multi-cycle control unit.
// State and class encodings are 3 bits so they can be exported for debug.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEMACC = 3'd4,
        S_WBACK  = 3'd5,
        S_BRANCH = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CL_ILLEGAL = 3'd0,
        CL_LDUR    = 3'd1,
        CL_STUR    = 3'd2,
        CL_CBZ     = 3'd3,
        CL_CBNZ    = 3'd4,
        CL_RTYPE   = 3'd5,
        CL_ITYPE   = 3'd6,
        CL_B       = 3'd7
    } opclass_t;

    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;

    localparam logic [10:0] MASK_CB  = 11'b11111111000;
    localparam logic [10:0] OP_CBZ   = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ  = 11'b10110101000;

    localparam logic [10:0] MASK_IMM = 11'b11111111110;
    localparam logic [10:0] OP_ADDI  = 11'b10010001000;
    localparam logic [10:0] OP_SUBI  = 11'b11010001000;

    localparam logic [10:0] MASK_B   = 11'b11111100000;
    localparam logic [10:0] OP_B     = 11'b00010100000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_ILLEGAL  = 2'b01;
    localparam logic [1:0] FC_FETCH_TO = 2'b10;
    localparam logic [1:0] FC_DATA_TO  = 2'b11;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] pat,
                                      input logic [10:0] mask);
        return (op & mask) == pat;
    endfunction

endpackage

// File: rtl/opclass_dec.sv
// Combinational opcode classifier; optional instruction groups fold into
// ILLEGAL when their enable parameter is cleared.
module opclass_dec
    import ctrl_pkg::*;
#(
    parameter bit EN_IMM = 1'b1,
    parameter bit EN_B   = 1'b1
) (
    input  logic [10:0] op,
    output opclass_t    cls
);

    always_comb begin
        cls = CL_ILLEGAL;
        if (op == OP_LDUR) begin
            cls = CL_LDUR;
        end else if (op == OP_STUR) begin
            cls = CL_STUR;
        end else if (op_match(op, OP_CBZ, MASK_CB)) begin
            cls = CL_CBZ;
        end else if (op_match(op, OP_CBNZ, MASK_CB)) begin
            cls = CL_CBNZ;
        end else if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) begin
            cls = CL_RTYPE;
        end else if (EN_IMM && (op_match(op, OP_ADDI, MASK_IMM) ||
                                op_match(op, OP_SUBI, MASK_IMM))) begin
            cls = CL_ITYPE;
        end else if (EN_B && op_match(op, OP_B, MASK_B)) begin
            cls = CL_B;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM with a bounded-wait memory handshake and a
// sticky fault state that only reset can leave.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter bit          EN_IMM      = 1'b1,
    parameter bit          EN_B        = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] Op,
    input  logic        Zero,
    input  logic        MemAck,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        IorD,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [1:0]  ALUOp,
    output logic        Fault,
    output logic [1:0]  FaultCode,
    output logic [2:0]  State
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit TMO_EN = (MEM_TIMEOUT != 0);

    state_t           state_q, state_d;
    opclass_t         cls_q, cls_d;
    opclass_t         dec_cls;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fc_q, fc_d;
    logic             mem_wait;
    logic             tmo_hit;

    opclass_dec #(
        .EN_IMM (EN_IMM),
        .EN_B   (EN_B)
    ) u_dec (
        .op  (Op),
        .cls (dec_cls)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cls_q   <= CL_ILLEGAL;
            cnt_q   <= '0;
            fc_q    <= FC_NONE;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            fc_q    <= fc_d;
        end
    end

    // MemAck in the final permitted cycle takes priority over the timeout.
    assign tmo_hit = TMO_EN && (cnt_q == CNT_LAST) && !MemAck;

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        fc_d     = fc_q;
        mem_wait = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        IorD     = 1'b0;
        Reg2Loc  = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUOp    = ALUOP_ADD;
        Fault    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                MemRead  = 1'b1;
                mem_wait = 1'b1;
                if (MemAck) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    fc_d    = FC_FETCH_TO;
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                case (dec_cls)
                    CL_RTYPE, CL_ITYPE, CL_LDUR, CL_STUR: state_d = S_EXEC;
                    CL_CBZ, CL_CBNZ, CL_B:                state_d = S_BRANCH;
                    default: begin
                        fc_d    = FC_ILLEGAL;
                        state_d = S_FAULT;
                    end
                endcase
            end
            S_EXEC: begin
                case (cls_q)
                    CL_RTYPE: begin
                        ALUOp   = ALUOP_RTYPE;
                        state_d = S_WBACK;
                    end
                    CL_ITYPE: begin
                        ALUSrc  = 1'b1;
                        ALUOp   = ALUOP_IMM;
                        state_d = S_WBACK;
                    end
                    CL_LDUR: begin
                        ALUSrc  = 1'b1;
                        state_d = S_MEMACC;
                    end
                    CL_STUR: begin
                        ALUSrc  = 1'b1;
                        Reg2Loc = 1'b1;
                        state_d = S_MEMACC;
                    end
                    default: begin
                        fc_d    = FC_ILLEGAL;
                        state_d = S_FAULT;
                    end
                endcase
            end
            S_MEMACC: begin
                IorD     = 1'b1;
                mem_wait = 1'b1;
                if (cls_q == CL_STUR) begin
                    Reg2Loc  = 1'b1;
                    MemWrite = 1'b1;
                end else begin
                    MemRead = 1'b1;
                end
                if (MemAck) begin
                    state_d = (cls_q == CL_STUR) ? S_FETCH : S_WBACK;
                end else if (tmo_hit) begin
                    fc_d    = FC_DATA_TO;
                    state_d = S_FAULT;
                end
            end
            S_WBACK: begin
                RegWrite = 1'b1;
                MemtoReg = (cls_q == CL_LDUR);
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                Reg2Loc = 1'b1;
                ALUOp   = ALUOP_PASSB;
                PCSrc   = 1'b1;
                PCWrite = (cls_q == CL_B) ||
                          ((cls_q == CL_CBZ) && Zero) ||
                          ((cls_q == CL_CBNZ) && !Zero);
                state_d = S_FETCH;
            end
            S_FAULT: Fault = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // Any state change restarts the wait count, so FETCH/MEMACC always enter at zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (mem_wait && !MemAck) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign FaultCode = fc_q;
    assign State     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: a memory responder issues instructions and pushes a
// per-instruction summary predicted from the ISA rules; a monitor rebuilds it.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    localparam int TMO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic [10:0] Op = '0;
    logic        Zero = 1'b0;
    logic        MemAck = 1'b0;
    logic        IRWrite, PCWrite, PCSrc, IorD, Reg2Loc, ALUSrc, MemtoReg, RegWrite;
    logic        MemRead, MemWrite, Fault;
    logic [1:0]  ALUOp, FaultCode;
    logic [2:0]  State;

    logic        rst_m = 1'b0;
    logic [10:0] op_m = '0;
    logic        ack_m = 1'b0;
    logic        IRWrite_m, PCWrite_m, PCSrc_m, IorD_m, Reg2Loc_m, ALUSrc_m, MemtoReg_m;
    logic        RegWrite_m, MemRead_m, MemWrite_m, Fault_m;
    logic [1:0]  ALUOp_m, FaultCode_m;
    logic [2:0]  State_m;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .EN_IMM(1'b1), .EN_B(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .Op(Op), .Zero(Zero), .MemAck(MemAck),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD),
        .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp), .Fault(Fault),
        .FaultCode(FaultCode), .State(State)
    );

    multicycle_ctrl #(.MEM_TIMEOUT(0), .EN_IMM(1'b0), .EN_B(1'b0)) dut_min (
        .clk(clk), .reset_n(rst_m), .Op(op_m), .Zero(1'b0), .MemAck(ack_m),
        .IRWrite(IRWrite_m), .PCWrite(PCWrite_m), .PCSrc(PCSrc_m), .IorD(IorD_m),
        .Reg2Loc(Reg2Loc_m), .ALUSrc(ALUSrc_m), .MemtoReg(MemtoReg_m), .RegWrite(RegWrite_m),
        .MemRead(MemRead_m), .MemWrite(MemWrite_m), .ALUOp(ALUOp_m), .Fault(Fault_m),
        .FaultCode(FaultCode_m), .State(State_m)
    );

    typedef struct {
        logic [10:0] op;
        logic        zero;
        int          flat;
        int          mlat;
    } instr_t;

    typedef struct packed {
        int         cycles;
        int         fetch;
        int         rd;
        int         wr;
        int         rw;
        int         m2r;
        int         alusrc;
        int         r2l;
        int         pcw_br;
        int         pcw_seq;
        int         irw;
        logic [1:0] aluop;
        logic [1:0] fcode;
    } sum_t;

    typedef enum {K_ILL, K_LD, K_ST, K_CBZ, K_CBNZ, K_R, K_I, K_B} kind_e;

    instr_t stim_q[$];
    sum_t   exp_q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    bit     drained = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic kind_e classify(input logic [10:0] op);
        kind_e k;
        casez (op)
            11'b11111000010: k = K_LD;
            11'b11111000000: k = K_ST;
            11'b10110100???: k = K_CBZ;
            11'b10110101???: k = K_CBNZ;
            11'b10001011000, 11'b11001011000,
            11'b10001010000, 11'b10101010000: k = K_R;
            11'b1001000100?, 11'b1101000100?: k = K_I;
            11'b000101?????: k = K_B;
            default:         k = K_ILL;
        endcase
        return k;
    endfunction

    // Expected observable footprint of one instruction, from fetch start to the next fetch or fault.
    function automatic sum_t model(input instr_t in);
        sum_t  s;
        kind_e k;
        int    mem;
        s = '0;
        if (in.flat >= TMO) begin
            s.cycles = TMO;
            s.fetch  = TMO;
            s.fcode  = 2'b10;
            return s;
        end
        s.fetch   = in.flat + 1;
        s.irw     = 1;
        s.pcw_seq = 1;
        s.cycles  = in.flat + 2;
        k = classify(in.op);
        case (k)
            K_ILL: s.fcode = 2'b01;
            K_R: begin
                s.cycles += 2;
                s.rw     = 1;
                s.aluop  = 2'b10;
            end
            K_I: begin
                s.cycles += 2;
                s.rw     = 1;
                s.alusrc = 1;
                s.aluop  = 2'b11;
            end
            K_LD, K_ST: begin
                mem = (in.mlat >= TMO) ? TMO : in.mlat + 1;
                s.cycles += 1 + mem;
                s.alusrc = 1;
                if (k == K_ST) begin
                    s.wr  = mem;
                    s.r2l = 1 + mem;
                end else begin
                    s.rd = mem;
                end
                if (in.mlat >= TMO) s.fcode = 2'b11;
                else if (k == K_LD) begin
                    s.cycles += 1;
                    s.rw     = 1;
                    s.m2r    = 1;
                end
            end
            default: begin
                s.cycles += 1;
                s.r2l    = 1;
                s.aluop  = 2'b01;
                s.pcw_br = ((k == K_B) || (k == K_CBZ && in.zero) ||
                            (k == K_CBNZ && !in.zero)) ? 1 : 0;
            end
        endcase
        return s;
    endfunction

    function automatic string fmt(input sum_t s);
        return $sformatf("cyc=%0d fetch=%0d rd=%0d wr=%0d rw=%0d m2r=%0d alusrc=%0d r2l=%0d pcbr=%0d pcseq=%0d irw=%0d aluop=%b fc=%b",
                         s.cycles, s.fetch, s.rd, s.wr, s.rw, s.m2r, s.alusrc, s.r2l,
                         s.pcw_br, s.pcw_seq, s.irw, s.aluop, s.fcode);
    endfunction

    function automatic logic [11:0] ctrl_vec();
        return {IRWrite, PCWrite, PCSrc, IorD, Reg2Loc, ALUSrc, MemtoReg, RegWrite,
                MemRead, MemWrite, ALUOp};
    endfunction

    // Memory responder: supplies the next instruction at each fetch and acks after its latency.
    instr_t cur;
    int     k_wait = 0;
    logic   r_prev_req = 1'b0, r_prev_iord = 1'b0;
    always @(negedge clk) begin
        logic req;
        int   lat;
        if (!reset_n) begin
            r_prev_req = 1'b0;
            k_wait     = 0;
            MemAck     = 1'b0;
        end else begin
            req = MemRead | MemWrite;
            if (req && (!r_prev_req || r_prev_iord != IorD)) begin
                k_wait = 0;
                if (!IorD) begin
                    if (stim_q.size() > 0) begin
                        cur  = stim_q.pop_front();
                        Op   = cur.op;
                        Zero = cur.zero;
                        exp_q.push_back(model(cur));
                    end else begin
                        drained  = 1'b1;
                        cur.flat = 1000;
                    end
                end
            end else if (req) begin
                k_wait++;
            end
            lat    = IorD ? cur.mlat : cur.flat;
            MemAck = req ? (k_wait == lat) : 1'($urandom_range(0, 1));
            r_prev_req  = req;
            r_prev_iord = IorD;
        end
    end

    // Monitor: accumulates one summary per instruction and scores it against the queue.
    sum_t acc;
    bit   span_open = 1'b0;
    logic m_prev_req = 1'b0, m_prev_iord = 1'b0;

    task automatic close_span();
        sum_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow: got %s expected nothing", fmt(acc));
        end else begin
            e = exp_q.pop_front();
            if (acc !== e) begin
                n_fail++;
                $display("FAIL instr_summary: got %s expected %s", fmt(acc), fmt(e));
            end
        end
        span_open = 1'b0;
    endtask

    always @(negedge clk) begin
        logic req, new_fetch;
        #2;
        if (!reset_n) begin
            span_open  = 1'b0;
            m_prev_req = 1'b0;
        end else begin
            req       = MemRead | MemWrite;
            new_fetch = MemRead && !IorD && (!m_prev_req || m_prev_iord);
            if (Fault) begin
                if (span_open) begin
                    acc.fcode = FaultCode;
                    chk("fault_outputs_quiet", 32'(ctrl_vec()), 32'd0);
                    close_span();
                end
            end else begin
                if (new_fetch && span_open) begin
                    acc.fcode = FaultCode;
                    close_span();
                end
                if (new_fetch) begin
                    span_open = 1'b1;
                    acc = '0;
                end
                if (span_open) begin
                    acc.cycles++;
                    if (MemRead && !IorD) acc.fetch++;
                    if (MemRead && IorD) acc.rd++;
                    if (MemWrite) acc.wr++;
                    if (RegWrite) acc.rw++;
                    if (MemtoReg) acc.m2r++;
                    if (ALUSrc) acc.alusrc++;
                    if (Reg2Loc) acc.r2l++;
                    if (PCWrite && PCSrc) acc.pcw_br++;
                    if (PCWrite && !PCSrc) acc.pcw_seq++;
                    if (IRWrite) acc.irw++;
                    acc.aluop |= ALUOp;
                end
            end
            m_prev_req  = req;
            m_prev_iord = IorD;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("reset_state", 32'(State), 32'(S_IDLE));
        chk("reset_outputs", 32'(ctrl_vec()), 32'd0);
        chk("reset_fault", 32'({Fault, FaultCode}), 32'd0);
        drained = 1'b0;
        @(negedge clk);
        #3;
        reset_n = 1'b1;
        #1;
        chk("idle_after_release", 32'({State, MemRead}), 32'({S_IDLE, 1'b0}));
        @(negedge clk);
        #2;
        chk("first_fetch", 32'({MemRead, IorD}), 32'b10);
    endtask

    task automatic run_stim();
        int cyc = 0;
        do_reset();
        while (!drained && !Fault && cyc < 400) begin
            @(negedge clk);
            #3;
            cyc++;
        end
        chk("episode_completes", 32'(cyc < 400), 32'd1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        stim_q.delete();
    endtask

    function automatic instr_t mk(input logic [10:0] op, input logic z, input int f, input int m);
        instr_t r;
        r.op = op; r.zero = z; r.flat = f; r.mlat = m;
        return r;
    endfunction

    function automatic instr_t rand_instr();
        logic [10:0] rops [4];
        logic [10:0] op;
        rops[0] = OP_ADD; rops[1] = OP_SUB; rops[2] = OP_AND; rops[3] = OP_ORR;
        case ($urandom_range(0, 9))
            0: op = 11'b11111000010;
            1: op = 11'b11111000000;
            2: op = {8'b10110100, 3'($urandom)};
            3: op = {8'b10110101, 3'($urandom)};
            4: op = rops[$urandom_range(0, 3)];
            5: op = {10'b1001000100, 1'($urandom)};
            6: op = {10'b1101000100, 1'($urandom)};
            7: op = {6'b000101, 5'($urandom)};
            default: op = 11'($urandom);
        endcase
        return mk(op, 1'($urandom), ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0) ? TMO + 1 : $urandom_range(0, 3));
    endfunction

    initial begin
        int cyc;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        stim_q = '{mk(11'b10001011000, 0, 0, 0), mk(11'b10001011000, 0, 0, 0)};
        run_stim();
        stim_q = '{mk(11'b11111000010, 0, 0, 3)};
        run_stim();
        stim_q = '{mk(11'b10110100101, 1, 0, 0), mk(11'b10110101000, 1, 0, 0),
                   mk(11'b10110101011, 0, 1, 0), mk(11'b00010111111, 0, 0, 0)};
        run_stim();
        stim_q = '{mk(11'b10001011000, 0, 4, 0)};
        run_stim();
        stim_q = '{mk(11'b10001011000, 0, 3, 0), mk(11'b10010001000, 0, 0, 0)};
        run_stim();
        stim_q = '{mk(11'b11111000000, 0, 0, 0), mk(11'b11111000000, 0, 0, 4)};
        run_stim();
        stim_q = '{mk(11'b11111000010, 0, 0, 3), mk(11'b11111111111, 0, 0, 0)};
        run_stim();

        // Asynchronous reset while a store is waiting on memory.
        stim_q = '{mk(11'b11111000000, 0, 0, 3)};
        do_reset();
        cyc = 0;
        while (!MemWrite && cyc < 50) begin
            @(negedge clk);
            #3;
            cyc++;
        end
        chk("stur_memwrite_seen", 32'(MemWrite), 32'd1);
        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("reset_drops_memwrite", 32'({MemWrite, IorD, Reg2Loc}), 32'd0);
        chk("reset_forces_idle", 32'(State), 32'(S_IDLE));
        chk("reset_clears_fault", 32'({Fault, FaultCode}), 32'd0);
        chk("stur_pending_in_sb", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        stim_q.delete();

        for (int ep = 0; ep < 25; ep++) begin
            int n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) stim_q.push_back(rand_instr());
            run_stim();
        end

        // Reduced configuration: ADDI and B disabled, timeout disabled.
        op_m = 11'b00010100000;
        ack_m = 1'b1;
        rst_m = 1'b0;
        @(negedge clk); #3; rst_m = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        chk("b_disabled_illegal", 32'({Fault_m, FaultCode_m}), 32'b101);
        op_m = 11'b10010001000;
        rst_m = 1'b0;
        @(negedge clk); #3; rst_m = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        chk("addi_disabled_illegal", 32'({Fault_m, FaultCode_m}), 32'b101);
        op_m = 11'b10001011000;
        rst_m = 1'b0;
        @(negedge clk); #3; rst_m = 1'b1;
        repeat (6) @(negedge clk);
        #2;
        chk("add_legal_no_fault", 32'(Fault_m), 32'd0);
        ack_m = 1'b0;
        rst_m = 1'b0;
        @(negedge clk); #3; rst_m = 1'b1;
        repeat (40) @(negedge clk);
        #2;
        chk("timeout_disabled_waits", 32'({Fault_m, MemRead_m, IorD_m, State_m}),
            32'({1'b0, 1'b1, 1'b0, S_FETCH}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
